// File: rtl/face_det_pkg.sv
// Shared constants and state encoding for the face-detection core front end.
package face_det_pkg;

    localparam int PIX_W      = 8;
    localparam int SUM_W      = 32;
    localparam int ADDR_W     = 17;
    localparam int MAX_TILE_W = 1024;
    localparam int DIM_W      = 16;
    localparam int LB_AW      = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/integral_image_gen_ii_line_buf.sv
// One-row buffer holding ii(x, y-1) for the row currently being summed.
module ii_line_buf
    import face_det_pkg::*;
(
    input  logic             clk,
    input  logic             i_we,
    input  logic [LB_AW-1:0] i_addr,
    input  logic [SUM_W-1:0] i_wdata,
    output logic [SUM_W-1:0] o_rdata
);

    logic [SUM_W-1:0] r_mem [MAX_TILE_W];

    // Write the new column sum; the read below still sees the previous row's value this cycle.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/integral_image_gen.sv
// Streams a raster-ordered greyscale tile and writes its summed-area image to the core's image RAM.
//  state | meaning
//  IDLE  | waiting for start
//  RUN   | accepting pixels
//  FLUSH | last write in flight
//  DONE  | one-cycle completion pulse
module integral_image_gen
    import face_det_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [DIM_W-1:0]  i_tile_w,
    input  logic [DIM_W-1:0]  i_tile_h,
    input  logic              i_pix_valid,
    input  logic [PIX_W-1:0]  i_pix_data,
    output logic              o_pix_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [SUM_W-1:0]  o_wr_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    state_t              r_state;
    state_t              w_next;
    logic [DIM_W-1:0]    r_tw, r_th, r_x, r_y;
    logic [ADDR_W-1:0]   r_addr;
    logic [SUM_W-1:0]    r_row_sum;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [SUM_W-1:0]    r_wr_data;
    logic                r_err;
    logic                w_accept, w_x_last, w_last, w_start_ok, w_bad, w_too_wide;
    logic [SUM_W-1:0]    w_row_sum, w_ii, w_lb_rd;

    assign w_accept   = i_pix_valid && (r_state == RUN);
    assign w_x_last   = (r_x == r_tw - DIM_W'(1));
    assign w_last     = w_x_last && (r_y == r_th - DIM_W'(1));
    assign w_start_ok = i_start && (r_state == IDLE);
    assign w_too_wide = (i_tile_w > DIM_W'(MAX_TILE_W));
    assign w_bad      = (i_tile_w == '0) || (i_tile_h == '0) || w_too_wide;
    assign w_row_sum  = ((r_x == '0) ? '0 : r_row_sum) + SUM_W'(i_pix_data);
    assign w_ii       = w_row_sum + ((r_y == '0) ? '0 : w_lb_rd);

    ii_line_buf u_line_buf (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (r_x[LB_AW-1:0]),
        .i_wdata (w_ii),
        .o_rdata (w_lb_rd)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode; an illegal size skips straight to the completion pulse.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = w_bad ? DONE : RUN;
            RUN:     if (w_accept && w_last) w_next = FLUSH;
            FLUSH:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State-decoded outputs plus the registered write port.
    always_comb begin
        o_pix_ready = (r_state == RUN);
        o_busy      = (r_state == RUN) || (r_state == FLUSH);
        o_done      = (r_state == DONE);
        o_wr_en     = r_wr_en;
        o_wr_addr   = r_wr_addr;
        o_wr_data   = r_wr_data;
        o_err       = r_err;
    end

    // Tile geometry capture, raster counters, row accumulator and write register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tw      <= '0;
            r_th      <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_addr    <= '0;
            r_row_sum <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_wr_en <= w_accept;
            if (w_start_ok) begin
                r_tw      <= i_tile_w;
                r_th      <= i_tile_h;
                r_x       <= '0;
                r_y       <= '0;
                r_addr    <= '0;
                r_row_sum <= '0;
                r_err     <= w_too_wide;
            end else if (w_accept) begin
                r_row_sum <= w_row_sum;
                r_wr_addr <= r_addr;
                r_wr_data <= w_ii;
                r_addr    <= r_addr + ADDR_W'(1);
                if (w_x_last) begin
                    r_x <= '0;
                    r_y <= r_y + DIM_W'(1);
                end else begin
                    r_x <= r_x + DIM_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_integral_image_gen.sv
// Scoreboard bench for integral_image_gen: expected writes are queued as each tile is set up.
module tb_integral_image_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic [15:0] i_tile_w, i_tile_h;
    logic        i_pix_valid;
    logic [7:0]  i_pix_data;
    logic        o_pix_ready, o_wr_en, o_busy, o_done, o_err;
    logic [16:0] o_wr_addr;
    logic [31:0] o_wr_data;

    typedef struct {
        logic [16:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] pix_mem [0:4095];

    integral_image_gen dut (
        .clk         (clk),
        .reset       (reset),
        .i_start     (i_start),
        .i_tile_w    (i_tile_w),
        .i_tile_h    (i_tile_h),
        .i_pix_valid (i_pix_valid),
        .i_pix_data  (i_pix_data),
        .o_pix_ready (o_pix_ready),
        .o_wr_en     (o_wr_en),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Write monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && o_wr_en) begin
            if (sb.size() == 0) begin
                chk("wr_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 64'(o_wr_addr), 64'(e.addr));
                chk("wr_data", 64'(o_wr_data), 64'(e.data));
            end
        end
    end

    // mode 0: all pixels = val, mode 1: random. n_drive < w*h stops early without waiting for done.
    task automatic run_tile(input int w, input int h, input int mode, input int val,
                            input bit stall, input int n_drive, input bit poke);
        int total, nd, idx, cyc, rs, v;
        bit bad, exp_err, rdy, prev;
        int prevrow [0:1023];
        bad     = (w == 0) || (h == 0) || (w > 1024);
        exp_err = (w > 1024);
        total   = bad ? 0 : w * h;
        rs      = 0;
        for (int y = 0; y < (bad ? 0 : h); y++) begin
            for (int x = 0; x < w; x++) begin
                pix_mem[y*w+x] = (mode == 0) ? 8'(val) : 8'($urandom_range(0, 255));
                rs = ((x == 0) ? 0 : rs) + int'(pix_mem[y*w+x]);
                v  = rs + ((y == 0) ? 0 : prevrow[x]);
                prevrow[x] = v;
                sb.push_back('{addr: 17'(y*w+x), data: 32'(v)});
            end
        end
        @(negedge clk);
        i_tile_w = 16'(w);
        i_tile_h = 16'(h);
        i_start  = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        nd  = (n_drive < total) ? n_drive : total;
        idx = 0;
        cyc = 0;
        while (idx < nd && cyc < 2000) begin
            if (poke && idx == 3) begin
                i_start  = 1'b1;
                i_tile_w = 16'd2;
            end else begin
                i_start = 1'b0;
            end
            i_pix_valid = !(stall && (cyc % 2 == 1));
            i_pix_data  = pix_mem[idx];
            rdy = o_pix_ready;
            if (i_pix_valid) chk("busy_run", 64'(o_busy), 1);
            @(posedge clk);
            if (i_pix_valid && rdy) idx++;
            cyc++;
            @(negedge clk);
        end
        i_pix_valid = 1'b0;
        i_start     = 1'b0;
        chk("pix_accepted", 64'(idx), 64'(nd));
        if (nd < total) return;
        if (total > 0) chk("ready_drop", 64'(o_pix_ready), 0);
        prev = 1'b0;
        cyc  = 0;
        while (!o_done && cyc < 20) begin
            prev = o_wr_en;
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", 64'(o_done), 1);
        if (total > 0) chk("done_after_last_wr", 64'(prev), 1);
        else           chk("empty_done_latency", 64'(cyc <= 1), 1);
        chk("err", 64'(o_err), 64'(exp_err));
        chk("sb_empty", 64'(sb.size()), 0);
        @(negedge clk);
        chk("done_one_cycle", 64'(o_done), 0);
        chk("idle_busy", 64'(o_busy), 0);
    endtask

    initial begin
        reset       = 1'b1;
        i_start     = 1'b0;
        i_tile_w    = '0;
        i_tile_h    = '0;
        i_pix_valid = 1'b0;
        i_pix_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", 64'(o_wr_en), 0);
        chk("rst_busy",  64'(o_busy), 0);
        chk("rst_done",  64'(o_done), 0);
        chk("rst_err",   64'(o_err), 0);
        chk("rst_ready", 64'(o_pix_ready), 0);
        chk("rst_addr",  64'(o_wr_addr), 0);
        chk("rst_data",  64'(o_wr_data), 0);
        reset = 1'b0;

        run_tile(3, 3, 0, 1,   1'b0, 100000, 1'b0);
        run_tile(3, 3, 0, 1,   1'b1, 100000, 1'b0);
        run_tile(4, 2, 0, 255, 1'b0, 100000, 1'b0);
        run_tile(0, 3, 0, 0,   1'b0, 100000, 1'b0);
        run_tile(3, 0, 0, 0,   1'b0, 100000, 1'b0);
        run_tile(1025, 1, 0, 0, 1'b0, 100000, 1'b0);
        run_tile(5, 4, 1, 0,   1'b1, 100000, 1'b0);

        run_tile(4, 4, 0, 7,   1'b0, 5, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk("abort_wr_en", 64'(o_wr_en), 0);
        chk("abort_busy",  64'(o_busy), 0);
        chk("abort_ready", 64'(o_pix_ready), 0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        run_tile(2, 2, 0, 2,   1'b0, 100000, 1'b0);

        run_tile(3, 3, 0, 1,   1'b0, 100000, 1'b1);
        run_tile(1, 1, 0, 200, 1'b0, 100000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
